// File: rtl/bram_mailbox_poller.sv
// Round-robin poller for a BRAM mailbox: reads a FIFO-ready flag and NUM_CH toggle-tagged
// channel words through port B. It also writes the local frame_ready level back to address 0.
module bram_mailbox_poller #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 2,
  parameter int OUT_W  = 20,
  parameter int RD_LAT = 1
) (
  input  logic                                           clk_6144mhz,
  input  logic                                           rst_n,
  input  logic                                           frame_ready,
  input  logic [DATA_W:0]                                bram_doutb,
  output logic                                           bram_web,
  output logic [ADDR_W-1:0]                              bram_addrb,
  output logic [DATA_W:0]                                bram_dinb,
  output logic                                           fifo_ready,
  output logic [OUT_W-1:0]                               data_out,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] data_ch,
  output logic                                           data_valid,
  output logic [NUM_CH-1:0]                              new_data_valid
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SLOT_W = $clog2(NUM_CH + 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("bram_mailbox_poller: NUM_CH must be 1..8");
  end
  if ((2 ** ADDR_W) < (NUM_CH + 2)) begin : g_bad_addr_w
    $error("bram_mailbox_poller: ADDR_W too small for NUM_CH+2 addresses");
  end
  if (OUT_W < DATA_W) begin : g_bad_out_w
    $error("bram_mailbox_poller: OUT_W must be >= DATA_W");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("bram_mailbox_poller: RD_LAT must be 1..3");
  end

  typedef enum logic {ST_READ = 1'b0, ST_WRITE = 1'b1} state_t;

  state_t              state_reg;
  logic [SLOT_W-1:0]   slot_reg;
  logic [SLOT_W-1:0]   slot_next;
  logic [1:0]          wait_reg;
  logic                last_wr_reg;
  logic [NUM_CH-1:0]   ch_hit;
  logic                toggle_seen;
  logic [CH_W-1:0]     ch_idx;

  // One-hot of the channel currently being polled (slot k+1 -> channel k).
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_hit
    assign ch_hit[gi] = (slot_reg == SLOT_W'(gi + 1));
  end

  always_comb begin
    slot_next   = (slot_reg == SLOT_W'(NUM_CH)) ? '0 : slot_reg + SLOT_W'(1);
    toggle_seen = |(ch_hit & new_data_valid);
    ch_idx      = CH_W'(slot_reg - SLOT_W'(1));
  end

  always_ff @(posedge clk_6144mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_READ;
      slot_reg       <= '0;
      wait_reg       <= '0;
      last_wr_reg    <= 1'b0;
      bram_web       <= 1'b0;
      bram_addrb     <= ADDR_W'(1);
      bram_dinb      <= '0;
      fifo_ready     <= 1'b0;
      data_out       <= '0;
      data_ch        <= '0;
      data_valid     <= 1'b0;
      new_data_valid <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state_reg)
        ST_READ: begin
          if (wait_reg != 2'(RD_LAT)) begin
            wait_reg <= wait_reg + 2'd1;
          end else begin
            wait_reg <= '0;
            slot_reg <= slot_next;
            if (slot_reg == '0) begin
              fifo_ready <= bram_doutb[0];
            end else if (bram_doutb[0] != toggle_seen) begin
              data_out       <= OUT_W'(bram_doutb[DATA_W:1]);
              data_ch        <= ch_idx;
              new_data_valid <= (new_data_valid & ~ch_hit) | (ch_hit & {NUM_CH{bram_doutb[0]}});
              data_valid     <= 1'b1;
            end
            // A pending frame_ready change is written only between slots, never mid-slot.
            if (frame_ready != last_wr_reg) begin
              state_reg   <= ST_WRITE;
              bram_web    <= 1'b1;
              bram_addrb  <= '0;
              bram_dinb   <= {{DATA_W{1'b0}}, frame_ready};
              last_wr_reg <= frame_ready;
            end else begin
              bram_addrb <= ADDR_W'(slot_next) + ADDR_W'(1);
            end
          end
        end
        ST_WRITE: begin
          state_reg  <= ST_READ;
          bram_web   <= 1'b0;
          bram_dinb  <= '0;
          bram_addrb <= ADDR_W'(slot_reg) + ADDR_W'(1);
        end
        default: state_reg <= ST_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_mailbox_poller.sv
// Directed bench: a RD_LAT=1 instance with a writable BRAM model and a RD_LAT=2 instance
// with a fixed mailbox image, both with NUM_CH=2.
module tb_bram_mailbox_poller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_ready = 1'b0;
  logic       frame_ready2 = 1'b0;

  logic [8:0]  doutb, dinb, doutb2, dinb2;
  logic        web, web2, fifo_ready, fifo_ready2, data_valid, data_valid2;
  logic [1:0]  addrb, addrb2, ndv, ndv2;
  logic [19:0] data_out, data_out2;
  logic [0:0]  data_ch, data_ch2;

  logic [8:0]  mem [0:3];
  logic [8:0]  mem2 [0:3];
  logic [8:0]  q1, q2a, q2b;
  logic        host_we = 1'b0;
  logic [1:0]  host_addr = '0;
  logic [8:0]  host_data = '0;
  int          wr_count = 0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_mailbox_poller #(.DATA_W(8), .NUM_CH(2), .ADDR_W(2), .OUT_W(20), .RD_LAT(1)) dut (
    .clk_6144mhz(clk), .rst_n(rst_n), .frame_ready(frame_ready), .bram_doutb(doutb),
    .bram_web(web), .bram_addrb(addrb), .bram_dinb(dinb), .fifo_ready(fifo_ready),
    .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid), .new_data_valid(ndv)
  );

  bram_mailbox_poller #(.DATA_W(8), .NUM_CH(2), .ADDR_W(2), .OUT_W(20), .RD_LAT(2)) dut2 (
    .clk_6144mhz(clk), .rst_n(rst_n), .frame_ready(frame_ready2), .bram_doutb(doutb2),
    .bram_web(web2), .bram_addrb(addrb2), .bram_dinb(dinb2), .fifo_ready(fifo_ready2),
    .data_out(data_out2), .data_ch(data_ch2), .data_valid(data_valid2), .new_data_valid(ndv2)
  );

  // BRAM models: one-cycle read for dut, two-cycle read for dut2.
  always @(posedge clk) begin
    q1 <= mem[addrb];
    if (web) begin
      mem[addrb] <= dinb;
      wr_count   <= wr_count + 1;
    end
    if (host_we) mem[host_addr] <= host_data;
    q2a <= mem2[addrb2];
    q2b <= q2a;
  end
  assign doutb  = q1;
  assign doutb2 = q2b;

  initial begin
    mem2[0] = 9'h000;
    mem2[1] = 9'h001;
    mem2[2] = 9'h000;
    mem2[3] = {8'h77, 1'b1};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [8:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(posedge clk);
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic run_window(input int n, output int pulses, output logic [19:0] dout,
                            output logic [0:0] ch, output logic [1:0] nv);
    pulses = 0; dout = '0; ch = '0; nv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (data_valid) begin
        pulses++; dout = data_out; ch = data_ch; nv = ndv;
      end
    end
  endtask

  // Leaves the bench at the negedge of the first cycle of slot 1 (address 2).
  task automatic align_slot1(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (addrb == 2'd2 && n < 20) begin @(negedge clk); n++; end
    while (addrb != 2'd2 && n < 20) begin @(negedge clk); n++; end
    ok = (n < 20);
    if (!ok) check("align_timeout", 32'd0, 32'd1);
  endtask

  // Period in cycles from one slot-1 start to the next; optional one-cycle frame_ready glitch.
  task automatic measure_period(input bit glitch, output int n);
    logic [1:0] prev;
    n = 0;
    prev = 2'd2;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (glitch && n == 1) frame_ready = ~frame_ready;
      if (addrb == 2'd2 && prev != 2'd2) break;
      prev = addrb;
    end
  endtask

  int          pulses, per, wc0;
  logic [19:0] cap_out;
  logic [0:0]  cap_ch;
  logic [1:0]  cap_nv;
  bit          ok;
  logic [1:0]  exp_addr [0:11];

  initial begin
    exp_addr = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    host_write(2'd0, 9'h000);
    host_write(2'd1, 9'h001);
    host_write(2'd2, 9'h000);
    host_write(2'd3, 9'h000);
    #1;
    check("rst_web", 32'(web), 32'd0);
    check("rst_addrb", 32'(addrb), 32'd1);
    check("rst_dinb", 32'(dinb), 32'd0);
    check("rst_fifo_ready", 32'(fifo_ready), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_ch", 32'(data_ch), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_ndv", 32'(ndv), 32'd0);

    // Poll sequence and fifo_ready from cycle 2; cycle 0 is the interval before the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("seq_addr_c%0d", c), 32'(addrb), 32'(exp_addr[c]));
      check($sformatf("seq_web_c%0d", c), 32'(web), 32'd0);
      check($sformatf("seq_fifo_c%0d", c), 32'(fifo_ready), (c >= 2) ? 32'd1 : 32'd0);
    end

    // Channel 1 new word, then silence, then toggle back to 0.
    host_write(2'd3, {8'hA5, 1'b1});
    run_window(18, pulses, cap_out, cap_ch, cap_nv);
    check("ch1_a5_pulses", 32'(pulses), 32'd1);
    check("ch1_a5_data", 32'(cap_out), 32'h000A5);
    check("ch1_a5_ch", 32'(cap_ch), 32'd1);
    check("ch1_a5_ndv", 32'(cap_nv), 32'h2);
    run_window(12, pulses, cap_out, cap_ch, cap_nv);
    check("ch1_repeat_pulses", 32'(pulses), 32'd0);
    check("ch1_hold_data", 32'(data_out), 32'h000A5);
    host_write(2'd3, {8'h3C, 1'b0});
    run_window(18, pulses, cap_out, cap_ch, cap_nv);
    check("ch1_3c_pulses", 32'(pulses), 32'd1);
    check("ch1_3c_data", 32'(cap_out), 32'h0003C);
    check("ch1_3c_ndv", 32'(cap_nv), 32'h0);
    host_write(2'd2, {8'h5A, 1'b1});
    run_window(18, pulses, cap_out, cap_ch, cap_nv);
    check("ch0_5a_pulses", 32'(pulses), 32'd1);
    check("ch0_5a_data", 32'(cap_out), 32'h0005A);
    check("ch0_5a_ch", 32'(cap_ch), 32'd0);
    check("ch0_5a_ndv", 32'(cap_nv), 32'h1);

    // frame_ready rises at the start of slot 1; write follows the slot, then slot 2.
    align_slot1(ok);
    wc0 = wr_count;
    frame_ready = 1'b1;
    @(negedge clk);
    check("wr_no_preempt_web", 32'(web), 32'd0);
    check("wr_no_preempt_addr", 32'(addrb), 32'd2);
    @(negedge clk);
    check("wr_web", 32'(web), 32'd1);
    check("wr_addr", 32'(addrb), 32'd0);
    check("wr_dinb", 32'(dinb), 32'h001);
    @(negedge clk);
    check("wr_after_web", 32'(web), 32'd0);
    check("wr_after_addr", 32'(addrb), 32'd3);
    check("wr_count", 32'(wr_count - wc0), 32'd1);
    check("wr_mem0", 32'(mem[0]), 32'h001);

    // Glitch that reverts within a slot: no write, 6-cycle period.
    align_slot1(ok);
    wc0 = wr_count;
    frame_ready = 1'b0;
    measure_period(1'b1, per);
    check("glitch_period", 32'(per), 32'd6);
    check("glitch_no_write", 32'(wr_count - wc0), 32'd0);

    // A real change adds exactly one cycle to the period.
    align_slot1(ok);
    wc0 = wr_count;
    frame_ready = 1'b0;
    measure_period(1'b0, per);
    check("write_period", 32'(per), 32'd7);
    check("write_count", 32'(wr_count - wc0), 32'd1);
    check("write_mem0", 32'(mem[0]), 32'h000);

    // Asynchronous reset in the middle of a WRITE cycle.
    frame_ready = 1'b1;
    per = 0;
    do begin @(negedge clk); per++; end while (!web && per < 12);
    check("wait_write_seen", 32'(web), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_web", 32'(web), 32'd0);
    check("arst_addrb", 32'(addrb), 32'd1);
    check("arst_dinb", 32'(dinb), 32'd0);
    check("arst_fifo_ready", 32'(fifo_ready), 32'd0);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_data_ch", 32'(data_ch), 32'd0);
    check("arst_data_valid", 32'(data_valid), 32'd0);
    check("arst_ndv", 32'(ndv), 32'd0);

    // RD_LAT=2 instance: 3-cycle slots, 9-cycle period, samples delayed two cycles.
    frame_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("lat2_addr_c%0d", c), 32'(addrb2), (c < 9) ? 32'(c / 3 + 1) : 32'd1);
      check($sformatf("lat2_fifo_c%0d", c), 32'(fifo_ready2), (c >= 3) ? 32'd1 : 32'd0);
      check($sformatf("lat2_dv_c%0d", c), 32'(data_valid2), (c == 9) ? 32'd1 : 32'd0);
    end
    check("lat2_data_out", 32'(data_out2), 32'h00077);
    check("lat2_data_ch", 32'(data_ch2), 32'd1);
    check("lat2_ndv", 32'(ndv2), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
